delay_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one programmable delay timer among up to NREQ game-logic requesters: ball stepper, left paddle, right paddle. A requester raises a level request, receives a one-hot grant, and gets a one-cycle done pulse after exactly DELAY_CYCLES clocks of counting. It sits between the pong game FSMs and the motion-rate timing, and replaces per-requester delay counters with a single counter.

---
 rtl/pong_defs.sv | 13 +
 rtl/rr_pick.sv | 31 +++
 rtl/delay_arbiter.sv | 100 ++++++++++
 tb/tb_delay_arbiter.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/pong_defs.sv
// Shared definitions for the pong timing blocks: arbiter state encodings
// and the default motion-rate delay.
package pong_defs;

  typedef enum logic [1:0] {
    SIDLE  = 2'b00,
    SCOUNT = 2'b01,
    SDONE  = 2'b10
  } state_t;

  localparam int DELAY_10MS = 1000000;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: one-hot pick of the first set req bit
// at or after ptr, wrapping back to bit 0.
module rr_pick #(
  parameter int NREQ  = 3,
  parameter int PTR_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NREQ-1:0]  pick,
  output logic             valid
);

  // First pass covers ptr..NREQ-1, second pass the wrapped range 0..ptr-1.
  always_comb begin
    pick  = '0;
    valid = 1'b0;
    for (int j = 0; j < NREQ; j++) begin
      if (!valid && req[j] && (j >= int'(ptr))) begin
        pick[j] = 1'b1;
        valid   = 1'b1;
      end
    end
    for (int j = 0; j < NREQ; j++) begin
      if (!valid && req[j]) begin
        pick[j] = 1'b1;
        valid   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/delay_arbiter.sv
// Round-robin arbiter that time-shares one delay counter among the pong
// requesters; each grant counts DELAY_CYCLES clocks then pulses done.
module delay_arbiter
  import pong_defs::*;
#(
  parameter int NREQ         = 3,
  parameter int DELAY_CYCLES = DELAY_10MS,
  parameter int CNT_W        = 20
) (
  input  logic            CLK_100MHz,
  input  logic            Reset_n,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant,
  output logic [NREQ-1:0] done,
  output logic            busy
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DELAY_CYCLES - 1);

  state_t           state_q, state_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] owner, ptr_next;
  logic [NREQ-1:0]  pick;
  logic             pick_valid;

  rr_pick #(.NREQ(NREQ), .PTR_W(PTR_W)) u_pick (
    .req  (req),
    .ptr  (ptr_q),
    .pick (pick),
    .valid(pick_valid)
  );

  always_comb begin
    owner = '0;
    for (int j = 0; j < NREQ; j++) begin
      if (grant_q[j]) owner = PTR_W'(j);
    end
    ptr_next = (owner == PTR_W'(NREQ - 1)) ? '0 : owner + 1'b1;
  end

  always_ff @(posedge CLK_100MHz) begin
    if (!Reset_n) begin
      state_q <= SIDLE;
      grant_q <= '0;
      count_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      count_q <= count_d;
      ptr_q   <= ptr_d;
    end
  end

  // Owner dropping req aborts the count; that check wins over terminal count.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    count_d = count_q;
    ptr_d   = ptr_q;
    case (state_q)
      SIDLE: begin
        grant_d = '0;
        if (pick_valid) begin
          grant_d = pick;
          count_d = '0;
          state_d = SCOUNT;
        end
      end
      SCOUNT: begin
        if ((req & grant_q) == '0) begin
          state_d = SIDLE;
          grant_d = '0;
          ptr_d   = ptr_next;
        end else if (count_q == LAST) begin
          state_d = SDONE;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      SDONE: begin
        state_d = SIDLE;
        grant_d = '0;
        ptr_d   = ptr_next;
      end
      default: begin
        state_d = SIDLE;
        grant_d = '0;
      end
    endcase
  end

  assign grant = grant_q;
  assign done  = (state_q == SDONE) ? grant_q : '0;
  assign busy  = (state_q != SIDLE);

endmodule

// File: tb/tb_delay_arbiter.sv
// Directed bench for delay_arbiter with NREQ=3, DELAY_CYCLES=4.
module tb_delay_arbiter;

  logic       CLK_100MHz = 1'b0;
  logic       Reset_n;
  logic [2:0] req;
  logic [2:0] grant;
  logic [2:0] done;
  logic       busy;
  int         checks = 0;
  int         errors = 0;

  always #5 CLK_100MHz = ~CLK_100MHz;

  delay_arbiter #(.NREQ(3), .DELAY_CYCLES(4), .CNT_W(20)) dut (
    .CLK_100MHz(CLK_100MHz),
    .Reset_n   (Reset_n),
    .req       (req),
    .grant     (grant),
    .done      (done),
    .busy      (busy)
  );

  task automatic tick();
    @(posedge CLK_100MHz);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_outs(input string tag, input logic [2:0] g, input logic [2:0] d,
                             input logic b);
    check({tag, " grant"}, 32'(grant), 32'(g));
    check({tag, " done"},  32'(done),  32'(d));
    check({tag, " busy"},  32'(busy),  32'(b));
  endtask

  // From the idle cycle whose closing edge samples req: four counting
  // cycles, then the done cycle. Returns positioned in the done cycle.
  task automatic serve(input string tag, input logic [2:0] g);
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_outs({tag, " count"}, g, 3'b000, 1'b1);
    end
    tick();
    expect_outs({tag, " sdone"}, g, g, 1'b1);
  endtask

  initial begin
    Reset_n = 1'b0;
    req     = 3'b111;
    tick();
    tick();
    expect_outs("reset", 3'b000, 3'b000, 1'b0);

    // all requesting: rotation 0,1,2
    Reset_n = 1'b1;
    serve("rr0", 3'b001);
    req = 3'b110;
    tick();
    expect_outs("rr0 idle", 3'b000, 3'b000, 1'b0);
    serve("rr1", 3'b010);
    req = 3'b100;
    tick();
    expect_outs("rr1 idle", 3'b000, 3'b000, 1'b0);
    serve("rr2", 3'b100);
    req = 3'b000;
    tick();
    expect_outs("rr2 idle", 3'b000, 3'b000, 1'b0);

    // single request
    req = 3'b001;
    serve("single", 3'b001);
    req = 3'b000;
    tick();
    expect_outs("single idle", 3'b000, 3'b000, 1'b0);
    tick();
    expect_outs("single idle2", 3'b000, 3'b000, 1'b0);

    // ptr=1 now: 101 must go to requester 2 first
    req = 3'b101;
    serve("ptr1 first", 3'b100);
    req = 3'b001;
    tick();
    expect_outs("ptr1 idle", 3'b000, 3'b000, 1'b0);
    serve("ptr1 second", 3'b001);
    req = 3'b000;
    tick();
    expect_outs("ptr1 idle2", 3'b000, 3'b000, 1'b0);

    // abort in 2nd counting cycle
    req = 3'b010;
    tick();
    expect_outs("abort c1", 3'b010, 3'b000, 1'b1);
    tick();
    expect_outs("abort c2", 3'b010, 3'b000, 1'b1);
    req = 3'b000;
    tick();
    expect_outs("abort after", 3'b000, 3'b000, 1'b0);
    tick();
    expect_outs("abort after2", 3'b000, 3'b000, 1'b0);
    // ptr must now be 2
    req = 3'b111;
    tick();
    expect_outs("abort ptr2", 3'b100, 3'b000, 1'b1);
    req = 3'b000;
    tick();
    expect_outs("abort2", 3'b000, 3'b000, 1'b0);

    // reset in 3rd counting cycle
    req = 3'b010;
    tick();
    tick();
    tick();
    expect_outs("rst c3", 3'b010, 3'b000, 1'b1);
    Reset_n = 1'b0;
    tick();
    expect_outs("rst hit", 3'b000, 3'b000, 1'b0);
    tick();
    expect_outs("rst held", 3'b000, 3'b000, 1'b0);
    Reset_n = 1'b1;
    serve("rst regrant", 3'b010);
    req = 3'b000;
    tick();
    expect_outs("rst idle", 3'b000, 3'b000, 1'b0);

    // req held through done: re-granted two cycles later
    req = 3'b100;
    serve("hold", 3'b100);
    tick();
    expect_outs("hold idle", 3'b000, 3'b000, 1'b0);
    tick();
    expect_outs("hold regrant", 3'b100, 3'b000, 1'b1);
    req = 3'b000;
    tick();
    expect_outs("hold drop", 3'b000, 3'b000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
